axi_dma_job_arbiter: RTL and testbench

- Shares one scatter-gather DMA engine among C_NUM_REQ requesters. Each requester submits a job: direction, FPGA address and a stream of scatter-gather entries terminated by tlast.
- Round-robin arbitration. The granted job's entries are forwarded into the engine's scatter-gather stream, then the block triggers the engine, waits for completion and returns the 4-bit response to the owner.
- Sits between the client cores and the DMA engine's trigger/scatter-gather register interface.

---
 rtl/axi_dma_job_arbiter_if.sv | 51 +++++
 rtl/axi_dma_job_arbiter.sv | 171 +++++++++++++++++
 tb/tb_axi_dma_job_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_job_arbiter_if.sv
// Signal bundle between the job arbiter, its requesters and the DMA engine.
// The arbiter connects through the slave modport; surrounding logic uses master.
interface axi_dma_job_arbiter_if #(
  parameter int C_NUM_REQ          = 4,
  parameter int C_AXI_ADDR_WIDTH_H = 64,
  parameter int C_AXI_ADDR_WIDTH_F = 32
);
  localparam int SGW = C_AXI_ADDR_WIDTH_H + 16;

  logic [C_NUM_REQ-1:0]                    req_valid;
  logic [C_NUM_REQ-1:0]                    req_direction;
  logic [C_NUM_REQ*C_AXI_ADDR_WIDTH_F-1:0] req_fpga_addr;
  logic [C_NUM_REQ*SGW-1:0]                s_axis_sg_tdata;
  logic [C_NUM_REQ-1:0]                    s_axis_sg_tvalid;
  logic [C_NUM_REQ-1:0]                    s_axis_sg_tlast;
  logic [C_NUM_REQ-1:0]                    s_axis_sg_tready;
  logic [C_NUM_REQ-1:0]                    done;
  logic [3:0]                              done_response;
  logic                                    done_overflow;
  logic [C_NUM_REQ-1:0]                    grant;
  logic [SGW-1:0]                          m_axis_sg_tdata;
  logic                                    m_axis_sg_tvalid;
  logic                                    m_axis_sg_tready;
  logic                                    dma_trigger;
  logic                                    dma_direction;
  logic [C_AXI_ADDR_WIDTH_F-1:0]           dma_fpga_addr;
  logic                                    dma_busy;
  logic [3:0]                              dma_response;

  modport slave (
    input  req_valid, req_direction, req_fpga_addr,
    input  s_axis_sg_tdata, s_axis_sg_tvalid, s_axis_sg_tlast,
    output s_axis_sg_tready,
    output done, done_response, done_overflow, grant,
    output m_axis_sg_tdata, m_axis_sg_tvalid,
    input  m_axis_sg_tready,
    output dma_trigger, dma_direction, dma_fpga_addr,
    input  dma_busy, dma_response
  );

  modport master (
    output req_valid, req_direction, req_fpga_addr,
    output s_axis_sg_tdata, s_axis_sg_tvalid, s_axis_sg_tlast,
    input  s_axis_sg_tready,
    input  done, done_response, done_overflow, grant,
    input  m_axis_sg_tdata, m_axis_sg_tvalid,
    output m_axis_sg_tready,
    input  dma_trigger, dma_direction, dma_fpga_addr,
    output dma_busy, dma_response
  );
endinterface

// File: rtl/axi_dma_job_arbiter.sv
// Round-robin arbiter sharing one scatter-gather DMA engine among C_NUM_REQ job requesters:
// forwards the winner's SG entries, triggers the engine, returns its response to the owner.
module axi_dma_job_arbiter #(
  parameter int C_NUM_REQ          = 4,
  parameter int C_AXI_ADDR_WIDTH_H = 64,
  parameter int C_AXI_ADDR_WIDTH_F = 32,
  parameter int C_MAX_SG_ENTRIES   = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  axi_dma_job_arbiter_if.slave bus
);
  localparam int SGW  = C_AXI_ADDR_WIDTH_H + 16;
  localparam int AFW  = C_AXI_ADDR_WIDTH_F;
  localparam int IDXW = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
  localparam int CNTW = $clog2(C_MAX_SG_ENTRIES + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(C_MAX_SG_ENTRIES - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(C_NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_TRIGGER, S_WAIT_START, S_WAIT_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [IDXW-1:0]      ptr_q, ptr_d, gidx_q, gidx_d;
  logic [C_NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic                 dir_q, dir_d;
  logic [AFW-1:0]       addr_q, addr_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [3:0]           resp_q, resp_d;
  logic                 dovf_q, dovf_d;

  // Rotating priority scan starting at the pointer
  logic            win_found;
  logic [IDXW-1:0] win_idx;
  int              scan;
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int k = 0; k < C_NUM_REQ; k++) begin
      scan = (int'(ptr_q) + k) % C_NUM_REQ;
      if (!win_found && bus.req_valid[scan]) begin
        win_found = 1'b1;
        win_idx   = IDXW'(scan);
      end
    end
  end

  logic [SGW-1:0]       g_tdata;
  logic                 g_tvalid, g_tlast, beat_acc, trig;
  logic [SGW-1:0]       m_tdata;
  logic                 m_tvalid;
  logic [C_NUM_REQ-1:0] s_tready;

  assign g_tdata  = bus.s_axis_sg_tdata[gidx_q*SGW +: SGW];
  assign g_tvalid = bus.s_axis_sg_tvalid[gidx_q];
  assign g_tlast  = bus.s_axis_sg_tlast[gidx_q];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    dir_d    = dir_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    done_d   = '0;
    resp_d   = resp_q;
    dovf_d   = dovf_q;
    m_tdata  = '0;
    m_tvalid = 1'b0;
    s_tready = '0;
    beat_acc = 1'b0;
    trig     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Hold off one cycle after done so the owner can drop req_valid
        if (win_found && done_q == '0) begin
          gidx_d           = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          dir_d            = bus.req_direction[win_idx];
          addr_d           = bus.req_fpga_addr[win_idx*AFW +: AFW];
          ptr_d            = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
          state_d          = S_LOAD;
        end
      end
      S_LOAD: begin
        m_tdata  = g_tdata;
        m_tvalid = g_tvalid;
        s_tready = grant_q & {C_NUM_REQ{bus.m_axis_sg_tready}};
        beat_acc = g_tvalid & bus.m_axis_sg_tready;
        if (beat_acc) begin
          cnt_d = cnt_q + 1'b1;
          if (g_tlast) begin
            state_d = S_TRIGGER;
          end else if (cnt_q == CNT_LAST) begin
            ovf_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        s_tready = grant_q;
        beat_acc = g_tvalid;
        if (beat_acc && g_tlast) state_d = S_TRIGGER;
      end
      S_TRIGGER: begin
        trig    = 1'b1;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (bus.dma_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!bus.dma_busy) begin
          resp_d  = bus.dma_response;
          dovf_d  = ovf_q;
          done_d  = grant_q;
          grant_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= '0;
      resp_q  <= '0;
      dovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
      dovf_q  <= dovf_d;
    end
  end

  assign bus.s_axis_sg_tready = s_tready;
  assign bus.m_axis_sg_tdata  = m_tdata;
  assign bus.m_axis_sg_tvalid = m_tvalid;
  assign bus.dma_trigger      = trig;
  assign bus.dma_direction    = dir_q;
  assign bus.dma_fpga_addr    = addr_q;
  assign bus.grant            = grant_q;
  assign bus.done             = done_q;
  assign bus.done_response    = resp_q;
  assign bus.done_overflow    = dovf_q;
endmodule

// File: tb/tb_axi_dma_job_arbiter.sv
// Bench for axi_dma_job_arbiter: requester/engine models plus a job-level scoreboard
// that predicts owner, forwarded entries and completion fields per job.
module tb_axi_dma_job_arbiter;
  localparam int NREQ = 4, AH = 64, AF = 32, MAXE = 8, SGW = AH + 16, MAXL = 16, NPOOL = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_dma_job_arbiter_if #(.C_NUM_REQ(NREQ), .C_AXI_ADDR_WIDTH_H(AH), .C_AXI_ADDR_WIDTH_F(AF)) bif();

  axi_dma_job_arbiter #(
    .C_NUM_REQ(NREQ), .C_AXI_ADDR_WIDTH_H(AH), .C_AXI_ADDR_WIDTH_F(AF), .C_MAX_SG_ENTRIES(MAXE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );

  typedef struct {
    logic           dir;
    logic [AF-1:0]  addr;
    int             len;
    logic [3:0]     resp;
    int             blen;
  } job_t;

  job_t           pool [NPOOL];
  logic [SGW-1:0] ent  [NPOOL][MAXL];
  int             npool = 0;
  int             jq [NREQ][$];
  int             bi [NREQ];

  int             checks = 0, errs = 0;
  int             cyc = 0, ndone = 0, mptr = 0, owner = 0, cur_id = 0;
  bit             owner_active = 0, rnd = 0;
  int             trig_cnt = 0, eng_st = 0, eng_cnt = 0, fall_cyc = 0;
  logic [SGW-1:0] got [$];
  int             order [$];

  task automatic chk(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic add_job(input int r, input logic dir, input logic [AF-1:0] addr, input int len,
                         input logic [3:0] resp, input int blen);
    logic [95:0] rv;
    pool[npool] = '{dir, addr, len, resp, blen};
    for (int i = 0; i < len; i++) begin
      rv = {$urandom(), $urandom(), $urandom()};
      ent[npool][i] = rv[SGW-1:0];
    end
    jq[r].push_back(npool);
    npool++;
  endtask

  task automatic drive();
    bif.req_valid        = '0;
    bif.req_direction    = '0;
    bif.req_fpga_addr    = '0;
    bif.s_axis_sg_tdata  = '0;
    bif.s_axis_sg_tvalid = '0;
    bif.s_axis_sg_tlast  = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (jq[r].size() > 0) begin
        int id;
        id = jq[r][0];
        bif.req_valid[r]             = 1'b1;
        bif.req_direction[r]         = pool[id].dir;
        bif.req_fpga_addr[r*AF +: AF] = pool[id].addr;
        if (bi[r] < pool[id].len) begin
          bif.s_axis_sg_tvalid[r]          = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
          bif.s_axis_sg_tdata[r*SGW +: SGW] = ent[id][bi[r]];
          bif.s_axis_sg_tlast[r]           = (bi[r] == pool[id].len - 1);
        end
      end
    end
    bif.m_axis_sg_tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    bif.dma_response     = owner_active ? pool[cur_id].resp : 4'h0;
    case (eng_st)
      1: if (eng_cnt == 0) begin bif.dma_busy = 1'b1; eng_st = 2; eng_cnt = pool[cur_id].blen - 1; end
         else eng_cnt--;
      2: if (eng_cnt == 0) begin bif.dma_busy = 1'b0; eng_st = 0; fall_cyc = cyc; end
         else eng_cnt--;
      default: ;
    endcase
  endtask

  task automatic sample();
    chk("tready_nongranted", 128'(bif.s_axis_sg_tready & ~bif.grant), 128'(0));
    if (bif.grant != '0 && !owner_active) begin
      int exp_o;
      exp_o = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (mptr + k) % NREQ;
        if (exp_o < 0 && jq[j].size() > 0) exp_o = j;
      end
      if (exp_o < 0) chk("grant_spurious", 128'(bif.grant), 128'(0));
      else begin
        owner = exp_o; cur_id = jq[exp_o][0]; owner_active = 1; order.push_back(exp_o);
        mptr = (exp_o + 1) % NREQ;
        chk("grant", 128'(bif.grant), 128'(1 << exp_o));
        chk("dma_direction", 128'(bif.dma_direction), 128'(pool[cur_id].dir));
        chk("dma_fpga_addr", 128'(bif.dma_fpga_addr), 128'(pool[cur_id].addr));
      end
    end
    for (int r = 0; r < NREQ; r++)
      if (bif.s_axis_sg_tready[r] && bif.s_axis_sg_tvalid[r]) bi[r]++;
    if (bif.m_axis_sg_tvalid && bif.m_axis_sg_tready) got.push_back(bif.m_axis_sg_tdata);
    if (bif.dma_trigger) begin
      trig_cnt++;
      eng_st  = 1;
      eng_cnt = $urandom_range(0, 3);
    end
    if (bif.done != '0) begin
      if (!owner_active) chk("done_unexpected", 128'(bif.done), 128'(0));
      else begin
        int n;
        n = (pool[cur_id].len < MAXE) ? pool[cur_id].len : MAXE;
        chk("done", 128'(bif.done), 128'(1 << owner));
        chk("done_response", 128'(bif.done_response), 128'(pool[cur_id].resp));
        chk("done_overflow", 128'(bif.done_overflow), 128'(pool[cur_id].len > MAXE));
        chk("grant_cleared", 128'(bif.grant), 128'(0));
        chk("done_latency", 128'(cyc), 128'(fall_cyc + 1));
        chk("trigger_count", 128'(trig_cnt), 128'(1));
        chk("entries_consumed", 128'(bi[owner]), 128'(pool[cur_id].len));
        chk("beat_count", 128'(got.size()), 128'(n));
        for (int i = 0; i < n && i < got.size(); i++)
          chk("beat_data", 128'(got[i]), 128'(ent[cur_id][i]));
        void'(jq[owner].pop_front());
        bi[owner] = 0;
      end
      owner_active = 0; got.delete(); trig_cnt = 0; ndone++;
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    cyc++;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic run_jobs(input int n, input int budget);
    int target, t;
    target = ndone + n;
    t = 0;
    while (ndone < target && t < budget) begin cycle(); t++; end
    chk("run_jobs_completed", 128'(ndone), 128'(target));
  endtask

  task automatic model_reset();
    mptr = 0; owner_active = 0; got.delete(); trig_cnt = 0; eng_st = 0;
    bif.dma_busy = 1'b0;
    for (int r = 0; r < NREQ; r++) bi[r] = 0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, 128'({bif.grant, bif.done, bif.done_response, bif.done_overflow,
                              bif.m_axis_sg_tvalid, bif.s_axis_sg_tready, bif.dma_trigger,
                              bif.dma_direction}), 128'(0));
    chk({tag, "_data"}, 128'({bif.dma_fpga_addr, bif.m_axis_sg_tdata}), 128'(0));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int eo [5];
    int t;
    eo = '{0, 1, 2, 3, 0};
    bif.dma_busy = 1'b0;
    model_reset();
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset_outputs");
    @(posedge clk); #1 rst_n = 1'b1;

    // Single 3-entry job from requester 1
    add_job(1, 1'b1, 32'h1000, 3, 4'h0, 10);
    run_jobs(1, 200);

    // Fresh pointer, all four requesting 1-entry jobs
    pulse_reset();
    order.delete();
    add_job(0, 1'b0, $urandom(), 1, 4'h1, 2);
    add_job(1, 1'b1, $urandom(), 1, 4'h2, 3);
    add_job(2, 1'b0, $urandom(), 1, 4'h3, 1);
    add_job(3, 1'b1, $urandom(), 1, 4'h4, 2);
    add_job(0, 1'b1, $urandom(), 1, 4'h5, 1);
    run_jobs(5, 400);
    chk("rr_order_len", 128'(order.size()), 128'(5));
    for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", 128'(order[i]), 128'(eo[i]));

    // Nonzero engine response
    add_job(2, 1'b0, $urandom(), 2, 4'hA, 3);
    run_jobs(1, 200);

    // Overflow: 8 forwarded, 5 drained
    add_job(0, 1'b1, $urandom(), MAXE + 5, 4'h5, 4);
    run_jobs(1, 300);

    // Random backpressure and mixed requesters
    rnd = 1;
    for (int i = 0; i < 12; i++)
      add_job($urandom_range(0, NREQ - 1), 1'($urandom_range(0, 1)), $urandom(),
              $urandom_range(1, MAXE + 2), 4'($urandom_range(0, 15)), $urandom_range(1, 8));
    run_jobs(12, 4000);
    rnd = 0;

    // Reset while waiting for the engine to finish
    add_job(3, 1'b1, $urandom(), 2, 4'h7, 30);
    add_job(3, 1'b0, $urandom(), 2, 4'h9, 3);
    t = 0;
    while (!(eng_st == 2 && eng_cnt < 25) && t < 200) begin cycle(); t++; end
    chk("reached_wait_done", 128'(eng_st == 2 && eng_cnt < 25), 128'(1));
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset_outputs");
    void'(jq[3].pop_front());
    order.delete();
    pulse_reset();
    run_jobs(1, 200);
    chk("post_reset_owner", 128'(order.size() > 0 ? order[0] : -1), 128'(3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
